// File: rtl/jt12_op_acc.sv
// -----------------------------------------------------------------------------
// jt12_op_acc
//   Consumer end of the operator output bus. Each enabled slot delivers one
//   signed operator sample. Only the carrier operators of the channel's
//   algorithm are kept. They are summed into a per-channel sample, doubled,
//   saturated and panned. All panned channel samples of a frame are also
//   mixed into one stereo frame sample.
//
//   Slot order within a frame of 4*NUM_VOICES slots: group g = slot/NUM_VOICES
//   selects the operator (0=S1, 1=S3, 2=S2, 3=S4), and ch = slot%NUM_VOICES.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   clk_en     slot advance enable; every state change is gated by it
//   zero       marks slot 0 of a frame (qualified by clk_en)
//   op_result  signed 14-bit operator output for the current slot
//   alg        algorithm (0..7) of the current slot's channel
//   lr         pan {left,right} of the current channel, used on S4 slots
//   snd_ch     channel index of snd_left/snd_right
//   snd_left   signed per-channel left sample
//   snd_right  signed per-channel right sample
//   snd_valid  one-clk pulse: new per-channel sample
//   mix_left   signed frame mix, left
//   mix_right  signed frame mix, right
//   mix_valid  one-clk pulse: new frame mix
//
// Handshake: snd_valid and mix_valid are pure strobes with no back-pressure.
// Each is high for exactly one clk, in the cycle after the clk_en edge that
// produced the data. The data outputs hold their value until the next strobe.
// -----------------------------------------------------------------------------
module jt12_op_acc #(
  parameter int NUM_VOICES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        zero,
  input  logic [13:0] op_result,
  input  logic [2:0]  alg,
  input  logic [1:0]  lr,
  output logic [2:0]  snd_ch,
  output logic [15:0] snd_left,
  output logic [15:0] snd_right,
  output logic        snd_valid,
  output logic [15:0] mix_left,
  output logic [15:0] mix_right,
  output logic        mix_valid
);

  localparam int SLOTS = 4 * NUM_VOICES;
  localparam int SW    = $clog2(SLOTS);

  localparam logic [1:0] G_S1 = 2'd0;
  localparam logic [1:0] G_S3 = 2'd1;
  localparam logic [1:0] G_S2 = 2'd2;
  localparam logic [1:0] G_S4 = 2'd3;

  logic [SW-1:0]      slot_q;
  logic [SW-1:0]      slot_cur;
  logic [SW-1:0]      slot_nxt;
  logic               last_slot;
  logic [1:0]         grp;
  logic [2:0]         ch;
  logic               is_carrier;
  logic signed [16:0] x;
  logic signed [16:0] acc [0:NUM_VOICES-1];
  logic signed [16:0] acc_cur;
  logic signed [17:0] s_sum;
  logic signed [15:0] y;
  logic signed [15:0] pan_l;
  logic signed [15:0] pan_r;
  logic signed [18:0] mix_acc_l;
  logic signed [18:0] mix_acc_r;
  logic signed [18:0] tot_l;
  logic signed [18:0] tot_r;
  logic               frame_ok;

  function automatic logic [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767)       sat16 = 16'h7fff;
    else if (v < -19'sd32768) sat16 = 16'h8000;
    else                      sat16 = v[15:0];
  endfunction

  always_comb begin
    // A zero strobe overrides the counter, so this slot is processed as slot 0.
    slot_cur  = zero ? '0 : slot_q;
    last_slot = (slot_cur == SW'(SLOTS - 1));
    slot_nxt  = last_slot ? '0 : slot_cur + SW'(1);
    grp       = 2'(slot_cur / SW'(NUM_VOICES));
    ch        = 3'(slot_cur % SW'(NUM_VOICES));

    case (grp)
      G_S1:    is_carrier = (alg == 3'd7);
      G_S3:    is_carrier = (alg >= 3'd5);
      G_S2:    is_carrier = (alg >= 3'd4);
      default: is_carrier = 1'b1;
    endcase

    x       = is_carrier ? {{3{op_result[13]}}, op_result} : 17'sd0;
    acc_cur = acc[ch];
    s_sum   = {acc_cur[16], acc_cur} + {x[16], x};
    // s_sum << 1 held in 19 bits so sat16 sees the true value.
    y       = sat16({s_sum, 1'b0});
    pan_l   = lr[1] ? y : 16'sd0;
    pan_r   = lr[0] ? y : 16'sd0;
    tot_l   = mix_acc_l + {{3{pan_l[15]}}, pan_l};
    tot_r   = mix_acc_r + {{3{pan_r[15]}}, pan_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      frame_ok  <= 1'b0;
      mix_acc_l <= '0;
      mix_acc_r <= '0;
      snd_ch    <= '0;
      snd_left  <= '0;
      snd_right <= '0;
      snd_valid <= 1'b0;
      mix_left  <= '0;
      mix_right <= '0;
      mix_valid <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) acc[i] <= '0;
    end else begin
      snd_valid <= 1'b0;
      mix_valid <= 1'b0;
      if (clk_en) begin
        slot_q <= slot_nxt;
        if (zero) frame_ok <= 1'b1;

        case (grp)
          G_S1:       acc[ch] <= x;
          G_S3, G_S2: acc[ch] <= acc_cur + x;
          default: begin
            snd_ch    <= ch;
            snd_left  <= pan_l;
            snd_right <= pan_r;
            snd_valid <= 1'b1;
          end
        endcase

        if (grp == G_S4) begin
          if (last_slot) begin
            mix_left  <= sat16(tot_l);
            mix_right <= sat16(tot_r);
            mix_acc_l <= '0;
            mix_acc_r <= '0;
            // A frame only counts once it has begun on a zero-marked slot 0.
            mix_valid <= frame_ok;
          end else begin
            mix_acc_l <= tot_l;
            mix_acc_r <= tot_r;
          end
        end else if (zero) begin
          // A re-sync discards whatever the truncated frame had mixed so far.
          mix_acc_l <= '0;
          mix_acc_r <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_op_acc.sv
// -----------------------------------------------------------------------------
// tb_jt12_op_acc
//   Directed sequence for jt12_op_acc with a behavioural model that pushes
//   expected per-channel and frame-mix results into queues as each slot is
//   driven; the queues are popped when the DUT strobes its valid outputs.
// -----------------------------------------------------------------------------
module tb_jt12_op_acc;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        zero;
  logic [13:0] op_result;
  logic [2:0]  alg;
  logic [1:0]  lr;
  logic [2:0]  snd_ch;
  logic [15:0] snd_left;
  logic [15:0] snd_right;
  logic        snd_valid;
  logic [15:0] mix_left;
  logic [15:0] mix_right;
  logic        mix_valid;

  jt12_op_acc #(.NUM_VOICES(6)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero),
    .op_result(op_result), .alg(alg), .lr(lr),
    .snd_ch(snd_ch), .snd_left(snd_left), .snd_right(snd_right),
    .snd_valid(snd_valid), .mix_left(mix_left), .mix_right(mix_right),
    .mix_valid(mix_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [34:0] snd_q[$];
  logic [31:0] mix_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int mix_seen = 0;

  // Reference model state (frame of 24 slots, 6 channels)
  int m_slot;
  int m_acc[6];
  int m_mix_l;
  int m_mix_r;
  bit m_fok;

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_mix_l = 0; m_mix_r = 0; m_fok = 0;
    for (int i = 0; i < 6; i++) m_acc[i] = 0;
    snd_q.delete();
    mix_q.delete();
  endtask

  task automatic model_slot(input bit z, input int op, input int a, input bit [1:0] p);
    int s, g, c, xv, yv, pl, pr;
    bit car;
    if (z) begin
      m_fok = 1; m_mix_l = 0; m_mix_r = 0;
    end
    s = z ? 0 : m_slot;
    g = s / 6;
    c = s % 6;
    car = (g == 3) || (g == 2 && a >= 4) || (g == 1 && a >= 5) || (g == 0 && a == 7);
    xv = car ? op : 0;
    if (g == 0) m_acc[c] = xv;
    else if (g < 3) m_acc[c] = m_acc[c] + xv;
    else begin
      yv = sat(2 * (m_acc[c] + xv));
      pl = p[1] ? yv : 0;
      pr = p[0] ? yv : 0;
      snd_q.push_back({3'(c), 16'(pl), 16'(pr)});
      m_mix_l = m_mix_l + pl;
      m_mix_r = m_mix_r + pr;
      if (s == 23) begin
        if (m_fok) mix_q.push_back({16'(sat(m_mix_l)), 16'(sat(m_mix_r))});
        m_mix_l = 0; m_mix_r = 0;
      end
    end
    m_slot = (s == 23) ? 0 : s + 1;
  endtask

  task automatic check_outputs();
    logic [34:0] es;
    logic [31:0] em;
    n_assert++;
    assert (snd_valid === (snd_q.size() != 0)) else begin
      n_fail++;
      $error("FAIL snd_valid got %b exp %b", snd_valid, snd_q.size() != 0);
    end
    if (snd_valid === 1'b1 && snd_q.size() != 0) begin
      es = snd_q.pop_front();
      n_assert++;
      assert ({snd_ch, snd_left, snd_right} === es) else begin
        n_fail++;
        $error("FAIL snd_data got ch=%0d l=%0d r=%0d exp ch=%0d l=%0d r=%0d",
               snd_ch, $signed(snd_left), $signed(snd_right),
               es[34:32], $signed(es[31:16]), $signed(es[15:0]));
      end
    end
    snd_q.delete();
    n_assert++;
    assert (mix_valid === (mix_q.size() != 0)) else begin
      n_fail++;
      $error("FAIL mix_valid got %b exp %b", mix_valid, mix_q.size() != 0);
    end
    if (mix_valid === 1'b1) mix_seen++;
    if (mix_valid === 1'b1 && mix_q.size() != 0) begin
      em = mix_q.pop_front();
      n_assert++;
      assert ({mix_left, mix_right} === em) else begin
        n_fail++;
        $error("FAIL mix_data got l=%0d r=%0d exp l=%0d r=%0d",
               $signed(mix_left), $signed(mix_right), $signed(em[31:16]), $signed(em[15:0]));
      end
    end
    mix_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit en, input bit z, input int op, input int a, input bit [1:0] p);
    clk_en = en; zero = z; op_result = 14'(op); alg = 3'(a); lr = p;
    if (en) model_slot(z, op, a, p);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_assert++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_snd"}, int'({snd_ch, snd_left, snd_right, snd_valid}), 0);
    check_val({tag, "_mix"}, int'({mix_left, mix_right, mix_valid}), 0);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    rst_n = 1'b0; clk_en = 1'b0; zero = 1'b0; op_result = '0; alg = '0; lr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step(0, 0, 0, 0, 2'b00);

    // 1: alg 0, all 1000, both sides: y = 2000, mix = 12000
    for (int i = 0; i < 48; i++) step(1, i == 0, 1000, 0, 2'b11);
    check_val("t1_snd_left", $signed(snd_left), 2000);
    check_val("t1_mix_left", $signed(mix_left), 12000);
    check_val("t1_mix_right", $signed(mix_right), 12000);
    check_val("t1_mix_count", mix_seen, 2);

    // 2: alg 7, all 8191: per-channel and mix saturate
    for (int i = 0; i < 24; i++) step(1, 0, 8191, 7, 2'b11);
    check_val("t2_snd_right", $signed(snd_right), 32767);
    check_val("t2_mix_left", $signed(mix_left), 32767);

    // 3: alg 4, S1=S3=500, S2=-300, S4=100, left only: y = -400
    for (int i = 0; i < 24; i++)
      step(1, 0, (i < 12) ? 500 : (i < 18) ? -300 : 100, 4, 2'b10);
    check_val("t3_snd_left", $signed(snd_left), -400);
    check_val("t3_snd_right", $signed(snd_right), 0);
    check_val("t3_mix_left", $signed(mix_left), -2400);

    // 4: re-sync at slot 10; truncated frame gives no mix, next frame does
    base = mix_seen;
    for (int i = 0; i < 10; i++) step(1, i == 0, rnd_op(), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 24; i++) step(1, i == 0, rnd_op(), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
    check_val("t4_mix_count", mix_seen - base, 1);
    // negative saturation of a full frame
    for (int i = 0; i < 24; i++) step(1, 0, -8192, 7, 2'b11);
    check_val("t4_mix_neg_sat", $signed(mix_left), -32768);

    // 5: clk_en 1-in-3, reset mid-frame
    for (int i = 0; i < 40; i++) step((i % 3) == 0, i == 0, rnd_op(), $urandom_range(0, 7), 2'b11);
    rst_n = 1'b0;
    #2;
    check_zero_outputs("t5_async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = mix_seen;
    // a full frame without zero after reset must not mix
    for (int i = 0; i < 72; i++) step((i % 3) == 0, 0, rnd_op(), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
    check_val("t5_no_zero_frame", mix_seen - base, 0);
    for (int i = 0; i < 69; i++) step((i % 3) == 0, i == 0, rnd_op(), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
    check_val("t5_before_24", mix_seen - base, 0);
    for (int i = 0; i < 3; i++) step((i % 3) == 0, 0, rnd_op(), $urandom_range(0, 7), 2'b11);
    check_val("t5_after_24", mix_seen - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
